// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t      SEG_BLANK = 7'h7F;
    localparam seg7_t      SEG_DASH  = 7'h3F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    localparam seg7_t SEG_0 = 7'h40;
    localparam seg7_t SEG_1 = 7'h79;
    localparam seg7_t SEG_2 = 7'h24;
    localparam seg7_t SEG_3 = 7'h30;
    localparam seg7_t SEG_4 = 7'h19;
    localparam seg7_t SEG_5 = 7'h12;
    localparam seg7_t SEG_6 = 7'h02;
    localparam seg7_t SEG_7 = 7'h78;
    localparam seg7_t SEG_8 = 7'h00;
    localparam seg7_t SEG_9 = 7'h10;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern.
// Non-decimal codes show a dash, except BCD_BLANK which turns every segment off.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (nibble)
            4'd0:      pattern = SEG_0;
            4'd1:      pattern = SEG_1;
            4'd2:      pattern = SEG_2;
            4'd3:      pattern = SEG_3;
            4'd4:      pattern = SEG_4;
            4'd5:      pattern = SEG_5;
            4'd6:      pattern = SEG_6;
            4'd7:      pattern = SEG_7;
            4'd8:      pattern = SEG_8;
            4'd9:      pattern = SEG_9;
            BCD_BLANK: pattern = SEG_BLANK;
            default:   pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner with frame-synchronous shadow
// latch and an all-anodes-off guard interval at the start of each digit slot.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 125000,
    parameter int GUARD    = 1250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    output logic [3:0]  an,
    output seg7_t       seg,
    output logic        frame_stb
);

    localparam int             CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] div_cnt, div_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [15:0]   shadow, shadow_nxt;
    logic          slot_end, latch, guard_nxt;
    logic [3:0]    nibble_nxt;
    seg7_t         seg_nxt;

    // Outputs are registered from next-state so each value lands in the
    // same cycle as the slot/cycle position it describes.
    always_comb begin
        slot_end   = (div_cnt == LAST);
        latch      = slot_end && (idx == 2'd3);
        div_nxt    = slot_end ? '0 : div_cnt + CW'(1);
        idx_nxt    = slot_end ? idx + 2'd1 : idx;
        shadow_nxt = latch ? bcd : shadow;
        nibble_nxt = shadow_nxt[{idx_nxt, 2'b00} +: 4];
        guard_nxt  = (int'(div_nxt) < GUARD);
    end

    seg7_decode u_decode (
        .nibble  (nibble_nxt),
        .pattern (seg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            idx       <= 2'd0;
            shadow    <= 16'hFFFF;
            an        <= 4'b1111;
            seg       <= SEG_BLANK;
            frame_stb <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            idx       <= idx_nxt;
            shadow    <= shadow_nxt;
            an        <= guard_nxt ? 4'b1111 : ~(4'b0001 << idx_nxt);
            seg       <= seg_nxt;
            frame_stb <= latch;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized bench for seg7_scan against a frame/slot arithmetic model
// (SCAN_DIV=8, GUARD=2, 8 ns clock).
`timescale 1ns/1ps
module tb_seg7_scan;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_stb;

    int          vectors = 0;
    int          errors  = 0;
    int          t       = 0;
    logic [15:0] m_shadow = 16'hFFFF;

    always #4 clk = ~clk;

    seg7_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd       (bcd),
        .an        (an),
        .seg       (seg),
        .frame_stb (frame_stb)
    );

    function automatic logic [6:0] ref_pattern(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F};
        return tbl[d];
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    // Expected outputs for position t since reset release.
    task automatic check_outputs();
        int slot, n;
        logic [3:0] exp_an;
        logic [3:0] dig;
        slot   = (t / SD) % 4;
        n      = t % SD;
        exp_an = (n < GD) ? 4'b1111 : ~(4'(1) << slot);
        dig    = 4'((m_shadow >> (4 * slot)) & 16'hF);
        check("an",        16'(an),        16'(exp_an));
        check("seg",       16'(seg),       16'(ref_pattern(dig)));
        check("frame_stb", 16'(frame_stb), 16'((t % FRAME == 0) && (t >= FRAME)));
    endtask

    // Called at a negedge; advances one cycle and checks at the next negedge.
    task automatic run_cycles(input int ncyc, input bit rnd);
        for (int i = 0; i < ncyc; i++) begin
            if (rnd) bcd = 16'($urandom);
            @(posedge clk);
            if (t % FRAME == FRAME - 1) m_shadow = bcd;
            t++;
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic run_to_pos(input int pos);
        int guard_cnt;
        guard_cnt = 0;
        while (t % FRAME != pos) begin
            run_cycles(1, 1'b0);
            guard_cnt++;
            if (guard_cnt > 2 * FRAME) begin
                check("run_to_pos_timeout", 16'(guard_cnt), 16'(0));
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  16'(an),        16'h000F);
        check({tag, "_seg"}, 16'(seg),       16'h007F);
        check({tag, "_stb"}, 16'(frame_stb), 16'h0000);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        t        = 0;
        m_shadow = 16'hFFFF;
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        bcd   = 16'h25FF;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Frame 1 blank, frame 2 shows "25__".
        release_reset();
        run_cycles(2 * FRAME, 1'b0);

        // Tearing: change during slot 1 of the current "25__" frame.
        run_to_pos(SD + 3);
        bcd = 16'hF25F;
        run_cycles(2 * FRAME, 1'b0);

        // Decode sweep on digit 0, loaded just before each latch.
        for (int v = 0; v < 16; v++) begin
            run_to_pos(FRAME - 1);
            bcd = {16'($urandom) & 16'hFFF0} | 16'(v);
            run_cycles(FRAME, 1'b0);
        end

        // Random bcd toggling every cycle.
        run_cycles(8 * FRAME, 1'b1);

        // Asynchronous reset in slot 2, cycle 5.
        run_to_pos(2 * SD + 5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset_hold");
        release_reset();
        run_cycles(3 * FRAME, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
